// File: rtl/jk_excitation_driver_pkg.sv
// Shared definitions for JK excitation logic: FSM state encodings and the
// per-bit excitation table (inverse of the JK characteristic table).
package jk_excitation_driver_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;

    // Returns {j, k} that moves a JK flip-flop from q to tgt in one clock.
    function automatic logic [1:0] jk_exc(input logic q, input logic tgt, input logic use_toggle);
        if (q == tgt) begin
            return 2'b00;
        end else if (use_toggle) begin
            return 2'b11;
        end else if (tgt) begin
            return 2'b10;
        end else begin
            return 2'b01;
        end
    endfunction

endpackage

// File: rtl/jk_exc_fifo.sv
// Small synchronous FIFO holding pending target vectors. Head data is
// presented combinationally; pointers carry an extra wrap bit for full/empty.
module jk_exc_fifo
    import jk_excitation_driver_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

    // Read/write pointers; reset flushes the FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives an external JK flip-flop bank through a stream of target states.
// Each target is popped from a FIFO, excited for one DRIVE cycle, then the
// bank's Q is compared against it at the end of the following CHECK cycle.
module jk_excitation_driver
    import jk_excitation_driver_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned USE_TOGGLE = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    input  logic             err_clr,
    output logic             err,
    output logic [WIDTH-1:0] err_bits,
    output logic [CNT_W-1:0] xfer_cnt
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] j_q, j_d;
    logic [WIDTH-1:0] k_q, k_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] err_bits_q, err_bits_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_head;
    logic [WIDTH-1:0] mismatch;
    logic             load;

    assign fifo_push = tgt_valid && !fifo_full;
    assign tgt_ready = !fifo_full;
    assign mismatch  = q ^ exp_q;

    jk_exc_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .data_i  (tgt_data),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Next-state logic: FSM sequencing, excitation load, check and error update.
    always_comb begin
        state_d    = state_q;
        j_d        = '0;
        k_d        = '0;
        exp_d      = exp_q;
        err_d      = err_q;
        err_bits_d = err_bits_q;
        cnt_d      = cnt_q;
        load       = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    load = 1'b1;
                end
            end
            DRIVE: begin
                state_d = CHECK;
            end
            CHECK: begin
                cnt_d = cnt_q + 1'b1;
                if (!fifo_empty) begin
                    load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            state_d = DRIVE;
            exp_d   = fifo_head;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                {j_d[i], k_d[i]} = jk_exc(q[i], fifo_head[i], USE_TOGGLE != 0);
            end
        end

        // A mismatch arriving on the same edge as err_clr replaces the sticky bits.
        if ((state_q == CHECK) && (mismatch != '0)) begin
            err_d      = 1'b1;
            err_bits_d = err_clr ? mismatch : (err_bits_q | mismatch);
        end else if (err_clr) begin
            err_d      = 1'b0;
            err_bits_d = '0;
        end
    end

    assign fifo_pop = load;

    // State registers; reset drops j/k immediately and discards any pending check.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            j_q        <= '0;
            k_q        <= '0;
            exp_q      <= '0;
            err_q      <= 1'b0;
            err_bits_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            j_q        <= j_d;
            k_q        <= k_d;
            exp_q      <= exp_d;
            err_q      <= err_d;
            err_bits_q <= err_bits_d;
            cnt_q      <= cnt_d;
        end
    end

    assign j        = j_q;
    assign k        = k_q;
    assign err      = err_q;
    assign err_bits = err_bits_q;
    assign xfer_cnt = cnt_q;
    assign busy     = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench for jk_excitation_driver with behavioural JK banks.
// u_dut: set/reset forms, CNT_W=16; u_tg: toggle forms, CNT_W=2 (wrap check).
module tb_jk_excitation_driver;

    logic       clk = 1'b0;
    logic       rst;
    // main instance
    logic       tgt_valid, tgt_ready, busy, err_clr, err;
    logic [3:0] tgt_data, j, k, err_bits, q_dut, bq, stuck;
    logic [15:0] xfer_cnt;
    // toggle instance
    logic       t2_valid, t2_ready, busy2, err_clr2, err2;
    logic [3:0] t2_data, j2, k2, err_bits2, bq2;
    logic [1:0] xfer_cnt2;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic       mon_en = 1'b0;
    logic [3:0] last_q;
    logic [3:0] seen[$];
    int         drive_cyc[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // behavioural JK banks: Q+ = J & ~Q | ~K & Q
    always @(posedge clk or negedge rst) begin
        if (!rst) bq <= '0;
        else      bq <= (j & ~bq) | (~k & bq);
    end
    always @(posedge clk or negedge rst) begin
        if (!rst) bq2 <= '0;
        else      bq2 <= (j2 & ~bq2) | (~k2 & bq2);
    end
    assign q_dut = bq & ~stuck;

    // records bank values and DRIVE cycles during the backpressure scenario
    always @(negedge clk) begin
        if (mon_en) begin
            if ((j | k) != 4'b0000) drive_cyc.push_back(cyc);
            if (q_dut != last_q) begin
                seen.push_back(q_dut);
                last_q = q_dut;
            end
        end
    end

    jk_excitation_driver #(
        .WIDTH(4), .DEPTH(4), .USE_TOGGLE(0), .CNT_W(16)
    ) u_dut (
        .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
        .tgt_data(tgt_data), .q(q_dut), .j(j), .k(k), .busy(busy),
        .err_clr(err_clr), .err(err), .err_bits(err_bits), .xfer_cnt(xfer_cnt)
    );

    jk_excitation_driver #(
        .WIDTH(4), .DEPTH(4), .USE_TOGGLE(1), .CNT_W(2)
    ) u_tg (
        .clk(clk), .rst(rst), .tgt_valid(t2_valid), .tgt_ready(t2_ready),
        .tgt_data(t2_data), .q(bq2), .j(j2), .k(k2), .busy(busy2),
        .err_clr(err_clr2), .err(err2), .err_bits(err_bits2), .xfer_cnt(xfer_cnt2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // push one target into an idle main DUT and advance into its DRIVE cycle
    task automatic push_main(input logic [3:0] d);
        tgt_valid = 1'b1;
        tgt_data  = d;
        tick();
        tgt_valid = 1'b0;
        tick();
    endtask

    task automatic push_tg(input logic [3:0] d);
        t2_valid = 1'b1;
        t2_data  = d;
        tick();
        t2_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; tgt_valid = 1'b1; tgt_data = 4'b1111;
        tick(); tick();
        n_cmp++; if (j !== 4'b0000) begin n_bad++; $display("FAIL rst_j: got %b expected 0000", j); end
        n_cmp++; if (k !== 4'b0000) begin n_bad++; $display("FAIL rst_k: got %b expected 0000", k); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b expected 0", err); end
        n_cmp++; if (xfer_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_cnt: got %0d expected 0", xfer_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
        tgt_valid = 1'b0;
        #2 rst = 1'b1;
        tick();
        n_cmp++; if (tgt_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b expected 1", tgt_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_nopush: busy got %b expected 0", busy); end
    endtask

    task automatic test_setreset();
        push_main(4'b1010);
        n_cmp++; if (j !== 4'b1010) begin n_bad++; $display("FAIL sr1_j: got %b expected 1010", j); end
        n_cmp++; if (k !== 4'b0000) begin n_bad++; $display("FAIL sr1_k: got %b expected 0000", k); end
        tick();
        n_cmp++; if (q_dut !== 4'b1010) begin n_bad++; $display("FAIL sr1_q: got %b expected 1010", q_dut); end
        n_cmp++; if ((j | k) !== 4'b0000) begin n_bad++; $display("FAIL sr1_chk_jk: got %b expected 0000", j | k); end
        tick();
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL sr1_err: got %b expected 0", err); end
        n_cmp++; if (xfer_cnt !== 16'd1) begin n_bad++; $display("FAIL sr1_cnt: got %0d expected 1", xfer_cnt); end
        push_main(4'b0110);
        n_cmp++; if (j !== 4'b0100) begin n_bad++; $display("FAIL sr2_j: got %b expected 0100", j); end
        n_cmp++; if (k !== 4'b1000) begin n_bad++; $display("FAIL sr2_k: got %b expected 1000", k); end
        tick(); tick();
        n_cmp++; if (q_dut !== 4'b0110) begin n_bad++; $display("FAIL sr2_q: got %b expected 0110", q_dut); end
        n_cmp++; if (xfer_cnt !== 16'd2) begin n_bad++; $display("FAIL sr2_cnt: got %0d expected 2", xfer_cnt); end
    endtask

    task automatic test_hold();
        push_main(4'b0110);
        n_cmp++; if ((j | k) !== 4'b0000) begin n_bad++; $display("FAIL hold_jk: got %b expected 0000", j | k); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL hold_busy: got %b expected 1", busy); end
        tick(); tick();
        n_cmp++; if (xfer_cnt !== 16'd3) begin n_bad++; $display("FAIL hold_cnt: got %0d expected 3", xfer_cnt); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL hold_err: got %b expected 0", err); end
    endtask

    task automatic test_toggle();
        push_tg(4'b1010);
        n_cmp++; if (j2 !== 4'b1010 || k2 !== 4'b1010) begin n_bad++; $display("FAIL tg1_jk: got %b/%b expected 1010/1010", j2, k2); end
        tick(); tick();
        push_tg(4'b0110);
        n_cmp++; if (j2 !== 4'b1100 || k2 !== 4'b1100) begin n_bad++; $display("FAIL tg2_jk: got %b/%b expected 1100/1100", j2, k2); end
        tick(); tick();
        n_cmp++; if (bq2 !== 4'b0110) begin n_bad++; $display("FAIL tg2_q: got %b expected 0110", bq2); end
        n_cmp++; if (err2 !== 1'b0) begin n_bad++; $display("FAIL tg2_err: got %b expected 0", err2); end
        n_cmp++; if (xfer_cnt2 !== 2'd2) begin n_bad++; $display("FAIL tg2_cnt: got %0d expected 2", xfer_cnt2); end
        push_tg(4'b1010); tick(); tick();
        push_tg(4'b0110); tick(); tick();
        n_cmp++; if (xfer_cnt2 !== 2'd0) begin n_bad++; $display("FAIL tg_wrap_cnt: got %0d expected 0", xfer_cnt2); end
        n_cmp++; if (bq2 !== 4'b0110) begin n_bad++; $display("FAIL tg_wrap_q: got %b expected 0110", bq2); end
    endtask

    // With one pop per two cycles, 7 back-to-back pushes fill a 4-deep FIFO,
    // so the 8th attempt is the one that stalls for exactly one cycle.
    task automatic test_back_to_back();
        logic [3:0] v [8];
        int stall_at, stalls, n;
        v[0] = 4'b1111; v[1] = 4'b0000; v[2] = 4'b0011; v[3] = 4'b1100;
        v[4] = 4'b0101; v[5] = 4'b1010; v[6] = 4'b1001; v[7] = 4'b0110;
        stall_at = -1; stalls = 0;
        seen.delete(); drive_cyc.delete();
        last_q = q_dut;
        mon_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tgt_valid = 1'b1;
            tgt_data  = v[i];
            n = 0;
            while (!tgt_ready && n < 8) begin
                if (stall_at < 0) stall_at = i;
                stalls++;
                tick();
                n++;
            end
            tick();
        end
        tgt_valid = 1'b0;
        n = 0;
        while (busy && n < 40) begin tick(); n++; end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_timeout: busy got %b expected 0", busy); end
        tick();
        mon_en = 1'b0;
        n_cmp++; if (stall_at !== 7) begin n_bad++; $display("FAIL b2b_stall_at: got %0d expected 7", stall_at); end
        n_cmp++; if (stalls !== 1) begin n_bad++; $display("FAIL b2b_stalls: got %0d expected 1", stalls); end
        n_cmp++; if (seen.size() !== 8) begin n_bad++; $display("FAIL b2b_nvals: got %0d expected 8", seen.size()); end
        for (int i = 0; i < 8 && i < seen.size(); i++) begin
            n_cmp++; if (seen[i] !== v[i]) begin n_bad++; $display("FAIL b2b_val%0d: got %b expected %b", i, seen[i], v[i]); end
        end
        n_cmp++; if (drive_cyc.size() !== 8) begin n_bad++; $display("FAIL b2b_ndrive: got %0d expected 8", drive_cyc.size()); end
        for (int i = 1; i < drive_cyc.size(); i++) begin
            n_cmp++; if (drive_cyc[i] - drive_cyc[i-1] !== 2) begin n_bad++; $display("FAIL b2b_gap%0d: got %0d expected 2", i, drive_cyc[i] - drive_cyc[i-1]); end
        end
        n_cmp++; if (xfer_cnt !== 16'd11) begin n_bad++; $display("FAIL b2b_cnt: got %0d expected 11", xfer_cnt); end
    endtask

    task automatic test_fault();
        stuck = 4'b0001;
        push_main(4'b0001);
        n_cmp++; if (j !== 4'b0001 || k !== 4'b0110) begin n_bad++; $display("FAIL flt_jk: got %b/%b expected 0001/0110", j, k); end
        tick(); tick();
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL flt_err: got %b expected 1", err); end
        n_cmp++; if (err_bits !== 4'b0001) begin n_bad++; $display("FAIL flt_bits: got %b expected 0001", err_bits); end
        n_cmp++; if (xfer_cnt !== 16'd12) begin n_bad++; $display("FAIL flt_cnt: got %0d expected 12", xfer_cnt); end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        n_cmp++; if (err !== 1'b0 || err_bits !== 4'b0000) begin n_bad++; $display("FAIL flt_clr: got %b/%b expected 0/0000", err, err_bits); end
    endtask

    task automatic test_fault_reset();
        stuck = 4'b0101;
        push_main(4'b0001); tick(); tick();
        n_cmp++; if (err_bits !== 4'b0001) begin n_bad++; $display("FAIL fr_pre_bits: got %b expected 0001", err_bits); end
        stuck = 4'b0100;
        push_main(4'b0101);
        n_cmp++; if (j !== 4'b0100 || k !== 4'b0000) begin n_bad++; $display("FAIL fr_jk: got %b/%b expected 0100/0000", j, k); end
        tick();
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL fr_err: got %b expected 1", err); end
        n_cmp++; if (err_bits !== 4'b0100) begin n_bad++; $display("FAIL fr_bits: got %b expected 0100", err_bits); end
        n_cmp++; if (xfer_cnt !== 16'd14) begin n_bad++; $display("FAIL fr_cnt: got %0d expected 14", xfer_cnt); end
        // two targets queued, first one in DRIVE, second still in the FIFO
        tgt_valid = 1'b1; tgt_data = 4'b1110; tick();
        tgt_data = 4'b1111; tick();
        tgt_valid = 1'b0;
        n_cmp++; if (j !== 4'b1110 || k !== 4'b0001) begin n_bad++; $display("FAIL fr_drive_jk: got %b/%b expected 1110/0001", j, k); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if ((j | k) !== 4'b0000) begin n_bad++; $display("FAIL fr_rst_jk: got %b expected 0000", j | k); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL fr_rst_busy: got %b expected 0", busy); end
        n_cmp++; if (xfer_cnt !== 16'd0) begin n_bad++; $display("FAIL fr_rst_cnt: got %0d expected 0", xfer_cnt); end
        n_cmp++; if (err !== 1'b0 || err_bits !== 4'b0000) begin n_bad++; $display("FAIL fr_rst_err: got %b/%b expected 0/0000", err, err_bits); end
        stuck = 4'b0000;
        #2 rst = 1'b1;
        tick(); tick(); tick(); tick();
        n_cmp++; if (xfer_cnt !== 16'd0) begin n_bad++; $display("FAIL fr_post_cnt: got %0d expected 0", xfer_cnt); end
        n_cmp++; if (busy !== 1'b0 || (j | k) !== 4'b0000) begin n_bad++; $display("FAIL fr_post_idle: got busy=%b jk=%b expected 0/0000", busy, j | k); end
    endtask

    initial begin
        rst = 1'b0;
        tgt_valid = 1'b0; tgt_data = '0; err_clr = 1'b0; stuck = '0;
        t2_valid = 1'b0; t2_data = '0; err_clr2 = 1'b0;
        test_reset();
        test_setreset();
        test_hold();
        test_toggle();
        test_back_to_back();
        test_fault();
        test_fault_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
